// File: rtl/seq_pkg.sv
// Shared types and decode helpers for the datapath issue sequencer.
package seq_pkg;

  // Issue sequencer states: each instruction walks OP_A -> OP_B -> EXEC.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP_A = 2'd1,
    OP_B = 2'd2,
    EXEC = 2'd3
  } state_t;

  localparam int INSTR_W    = 32;
  localparam int REG_W      = 5;
  localparam int I_FLAG_BIT = 31;
  localparam int FCN_LSB    = 26;
  localparam int RD_LSB     = 21;
  localparam int RS1_LSB    = 16;
  // rs2 sits in the top of the low half-word, so it shares bit positions with the immediate.
  localparam int RS2_LSB    = 11;
  localparam int IMM_W      = 16;

  // Field layout mirrors the instruction word, MSB first.
  typedef struct packed {
    logic             i_flag;
    logic [REG_W-1:0] fcn;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [IMM_W-1:0] low;
  } instr_t;

  function automatic logic [INSTR_W-1:0] sext16(input logic [IMM_W-1:0] value);
    return {{(INSTR_W - IMM_W){value[IMM_W-1]}}, value};
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous instruction FIFO; pointers carry one extra wrap bit to tell full from empty.
module seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset empties the queue and drops any same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Issue controller: queues instruction words and replays each as an operand-A / operand-B / execute
// pattern on the shared-bus datapath control lines.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [4:0]         alu_function_sel,
  output logic               alu_store_1,
  output logic               alu_store_2,
  output logic               alu_broadcast,
  output logic [4:0]         register_index,
  output logic               register_read_enable,
  output logic               register_write_enable,
  output logic [31:0]        imm,
  output logic               imm_EN,
  output logic               busy,
  output logic [CNT_W-1:0]   retire_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t       state;
  instr_t       cur;
  logic [31:0]  head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;

  assign instr_ready = !fifo_full;
  assign push        = instr_valid && instr_ready;
  // A new instruction is only taken when the datapath is free or finishing the previous one.
  assign pop         = !fifo_empty && ((state == IDLE) || (state == EXEC));
  assign busy        = (state != IDLE) || !fifo_empty;

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (instr),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencing FSM, current-instruction latch and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur          <= '0;
      retire_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= OP_A;
            cur   <= instr_t'(head);
          end
        end
        OP_A: state <= OP_B;
        OP_B: state <= EXEC;
        EXEC: begin
          retire_count <= retire_count + CNT_ONE;
          if (!fifo_empty) begin
            state <= OP_A;
            cur   <= instr_t'(head);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the control lines; only one bus driver is ever enabled per state.
  always_comb begin
    alu_function_sel      = '0;
    alu_store_1           = 1'b0;
    alu_store_2           = 1'b0;
    alu_broadcast         = 1'b0;
    register_index        = '0;
    register_read_enable  = 1'b0;
    register_write_enable = 1'b0;
    imm                   = '0;
    imm_EN                = 1'b0;
    case (state)
      OP_A: begin
        register_index       = cur.rs1;
        register_read_enable = 1'b1;
        alu_store_1          = 1'b1;
      end
      OP_B: begin
        alu_store_2 = 1'b1;
        if (cur[I_FLAG_BIT]) begin
          imm    = sext16(cur.low);
          imm_EN = 1'b1;
        end else begin
          register_index       = cur.low[RS2_LSB +: REG_W];
          register_read_enable = 1'b1;
        end
      end
      EXEC: begin
        alu_function_sel      = cur.fcn;
        alu_broadcast         = 1'b1;
        register_index        = cur.rd;
        register_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle issue controller for the shared-bus datapath (register file, two ALU operand latches, ALU broadcast, immediate driver).
- Accepts 32-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each instruction onto the datapath control lines as a fixed 3-cycle operand-A / operand-B / execute pattern.
- Sits between the instruction source and the datapath, in place of hand-driven enables.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, at least 2.
- CNT_W, 16, retire counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  an instruction word is offered.
- instr  input  32  instruction word.
- instr_ready  output  1  FIFO can accept a word; equals !full.
- alu_function_sel  output  5  ALU function code.
- alu_store_1  output  1  latch bus into ALU operand 1.
- alu_store_2  output  1  latch bus into ALU operand 2.
- alu_broadcast  output  1  ALU result drives bus.
- register_index  output  5  register file address.
- register_read_enable  output  1  register file drives bus.
- register_write_enable  output  1  register file captures bus.
- imm  output  32  immediate value.
- imm_EN  output  1  immediate drives bus.
- busy  output  1  sequencing in progress or FIFO non-empty.
- retire_count  output  CNT_W  count of completed instructions.

Behaviour:
- Instruction format:
  - [31] I flag; [30:26] fcn; [25:21] rd; [20:16] rs1.
  - R-type: [15:11] rs2.
  - I-type: imm = sign-extend of [15:0].
- Push: a word is written when instr_valid && instr_ready.
- FIFO: first-in first-out, no drop, no overwrite. A push and a pop in the same cycle are both legal when the FIFO is not full.
  - When full, instr_ready is low, so a same-cycle pop does not enable a push.
  - instr_ready rises the cycle after the pop.
- FSM states: IDLE, OP_A, OP_B, EXEC.
  - IDLE → OP_A when FIFO non-empty: pop the head and latch it into the current-instruction register.
  - OP_A → OP_B, unconditionally.
  - OP_B → EXEC, unconditionally.
  - EXEC → OP_A if FIFO non-empty (popping that same cycle), else IDLE.
- Timing:
  - Throughput is exactly 1 instruction per 3 cycles when back-to-back.
  - Latency from the accepting edge of a push into an empty idle unit to the first OP_A cycle: 2 cycles (write, then pop).
- Outputs are Moore: decoded from the state and the latched instruction only. All outputs not listed for a state are 0.
  - IDLE: all outputs 0.
  - OP_A: register_index=rs1, register_read_enable=1, alu_store_1=1.
  - OP_B, R-type: register_index=rs2, register_read_enable=1, alu_store_2=1.
  - OP_B, I-type: imm=sext(instr[15:0]), imm_EN=1, alu_store_2=1, register_index=0.
  - EXEC: alu_function_sel=fcn, alu_broadcast=1, register_index=rd, register_write_enable=1.
- Bus exclusivity invariant: at most one of register_read_enable, imm_EN, alu_broadcast is high in any cycle.
- alu_function_sel is nonzero only in EXEC.
- retire_count increments on every edge leaving EXEC and wraps modulo 2^CNT_W.
- busy = (state != IDLE) || FIFO non-empty.
- Reset (any cycle, including mid-instruction):
  - State → IDLE, FIFO emptied, latched instruction cleared, retire_count → 0.
  - All control outputs are 0 in the cycle following reset; instr_ready is 1 once reset is low.
  - An instruction in flight at reset is abandoned and does not retire.
  - A push asserted in the same cycle as reset is discarded.

Decomposition:
- Package seq_pkg: state enum (IDLE, OP_A, OP_B, EXEC), instruction field bit positions, I-flag index, instruction struct typedef, sign-extend function.
- Sub-module seq_fifo: parameterised synchronous FIFO with full/empty flags and pointer-wrap logic.

Test Plan:
- Single R-type after reset: 0x0C62_1800 (fcn=3, rd=3, rs1=2, rs2=3).
  - OP_A: idx 2, rd_en, st1.
  - OP_B: idx 3, rd_en, st2.
  - EXEC: fcn 3, broadcast, idx 3, wr_en.
  - Afterwards retire_count=1 and busy=0.
- I-type 0x8421_FFFE: OP_B drives imm=0xFFFF_FFFE with imm_EN=1 and register_read_enable=0.
- Back-to-back: push 6 words with instr_valid held high (DEPTH=4).
  - instr_ready drops when full.
  - All 6 words issue in order at 3-cycle spacing; retire_count=6.
- Simultaneous push/pop at occupancy 2: occupancy stays 2 and order is preserved.
- Reset asserted during OP_B: next cycle all outputs are 0, busy=0, retire_count=0; the queued words never issue.
- retire_count wrap with CNT_W=2: the fifth retire yields 1; bus-exclusivity assertion holds over a random instruction stream.
